// File: rtl/bb_pkg.sv
// Shared constants, velocity field layout and FSM states for the brick-breaker
// ball datapath.
package bb_pkg;

  // Playfield defaults.
  localparam int unsigned SCREEN_W_DEF = 160;
  localparam int unsigned SCREEN_H_DEF = 120;

  // Bus widths of the ball stage.
  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned V_W = 3;

  // Velocity word: bit VDIR is the direction (1 = +axis), [VMAG_HI:VMAG_LO] magnitude.
  localparam int unsigned VDIR    = 2;
  localparam int unsigned VMAG_HI = 1;
  localparam int unsigned VMAG_LO = 0;

  // Colours.
  localparam logic [2:0] COLOR_BLACK = 3'b000;
  localparam logic [2:0] COLOR_WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_WAIT_TICK,
    ST_ERASE,
    ST_MOVE
  } state_t;

  // Saturating magnitude increment.
  function automatic logic [1:0] mag_inc(input logic [1:0] m);
    return (m == 2'd3) ? m : m + 2'd1;
  endfunction

endpackage

// File: rtl/ball_sprite_scan.sv
// Row-major BALL_SIZE x BALL_SIZE pixel scan used for both erase and draw.
// A start pulse arms the scan; pixel 0 is presented in the following cycle.
module ball_sprite_scan
  import bb_pkg::*;
#(
  parameter int unsigned BALL_SIZE = 2
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           start,
  input  logic [X_W-1:0] base_x,
  input  logic [Y_W-1:0] base_y,
  output logic [X_W-1:0] pix_x_c,
  output logic [Y_W-1:0] pix_y_c,
  output logic           valid_c,
  output logic           done_c
);

  localparam int unsigned CW = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BALL_SIZE - 1);

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          busy;

  // Pixel address follows the base, which is stable for the whole scan.
  assign pix_x_c = base_x + X_W'(col);
  assign pix_y_c = base_y + Y_W'(row);
  assign valid_c = busy;
  assign done_c  = busy && (col == LAST) && (row == LAST);

  // Column counter wraps into the row counter; the scan ends after the last pixel.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      busy <= 1'b0;
      col  <= '0;
      row  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      col  <= '0;
      row  <= '0;
    end else if (busy) begin
      if (col == LAST) begin
        col <= '0;
        if (row == LAST) begin
          row  <= '0;
          busy <= 1'b0;
        end else begin
          row <= row + CW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball physics and sprite stage: owns position/velocity, steps once per frame
// tick, reflects off walls, paddle and brick collision flags, and streams a
// sprite erase/draw to the plot arbiter.
// Optional feature: define BALL_SPEEDUP_EN to raise the ball speed every 8th
// brick hit (saturating at magnitude 3).
module ball_motion
  import bb_pkg::*;
#(
  parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
  parameter int unsigned BALL_SIZE  = 2,
  parameter int unsigned PADDLE_Y   = 112,
  parameter int unsigned PADDLE_W   = 16,
  parameter logic [2:0]  BALL_COLOR = COLOR_WHITE
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [7:0] paddle_x,
  input  logic       cX,
  input  logic       cY,
  output logic [7:0] ballX,
  output logic [6:0] ballY,
  output logic [2:0] vx,
  output logic [2:0] vy,
  output logic [7:0] outX,
  output logic [6:0] outY,
  output logic [2:0] outCOLOR,
  output logic       plot,
  output logic       miss,
  output logic       active
);

  localparam logic signed [8:0] X_MAX = 9'(SCREEN_W - BALL_SIZE);
  localparam logic signed [8:0] Y_MAX = 9'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] BS10 = 10'(BALL_SIZE);
  localparam logic [9:0] PY10 = 10'(PADDLE_Y);
  localparam logic [9:0] PW10 = 10'(PADDLE_W);
  localparam logic [X_W-1:0] LAUNCH_OFS = X_W'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [Y_W-1:0] REST_Y     = Y_W'(PADDLE_Y - BALL_SIZE);
  localparam logic [X_W-1:0] RESET_X    = X_W'(SCREEN_W / 2 - 1);
  localparam logic [V_W-1:0] VX_LAUNCH  = 3'b101;
  localparam logic [V_W-1:0] VY_LAUNCH  = 3'b001;

  state_t state;
  logic   tick_pend;
  logic   cx_lat;
  logic   cy_lat;

`ifdef BALL_SPEEDUP_EN
  logic [2:0] hit_cnt;
`endif

  logic [X_W-1:0] pix_x_c;
  logic [Y_W-1:0] pix_y_c;
  logic           scan_valid_c;
  logic           scan_done_c;
  logic           scan_start_c;

  logic signed [8:0] bx, by, mag_x, mag_y, nx, ny;
  logic [9:0]        nxu, nyu, prev_bot, px10;
  logic [V_W-1:0]    vx_n, vy_n;
  logic [X_W-1:0]    new_x;
  logic [Y_W-1:0]    new_y;
  logic              paddle_hit_c;
  logic              miss_c;

  ball_sprite_scan #(
    .BALL_SIZE(BALL_SIZE)
  ) u_scan (
    .Clock  (Clock),
    .Resetn (Resetn),
    .start  (scan_start_c),
    .base_x (ballX),
    .base_y (ballY),
    .pix_x_c(pix_x_c),
    .pix_y_c(pix_y_c),
    .valid_c(scan_valid_c),
    .done_c (scan_done_c)
  );

  // One MOVE step: brick flips, axis step, wall clamps, paddle bounce, miss.
  always_comb begin
    vx_n         = vx;
    vy_n         = vy;
    vx_n[VDIR]   = vx[VDIR] ^ cx_lat;
    vy_n[VDIR]   = vy[VDIR] ^ cy_lat;
    bx           = 9'(ballX);
    by           = 9'(ballY);
    mag_x        = 9'(vx[VMAG_HI:VMAG_LO]);
    mag_y        = 9'(vy[VMAG_HI:VMAG_LO]);
    nx           = vx_n[VDIR] ? (bx + mag_x) : (bx - mag_x);
    ny           = vy_n[VDIR] ? (by + mag_y) : (by - mag_y);
    if (nx < 9'sd0) begin
      nx         = 9'sd0;
      vx_n[VDIR] = 1'b1;
    end else if (nx > X_MAX) begin
      nx         = X_MAX;
      vx_n[VDIR] = 1'b0;
    end
    if (ny < 9'sd0) begin
      ny         = 9'sd0;
      vy_n[VDIR] = 1'b1;
    end
    // Both axes are non-negative after the clamps, so unsigned compares are safe.
    nxu          = 10'($unsigned(nx));
    nyu          = 10'($unsigned(ny));
    prev_bot     = 10'(ballY) + BS10;
    px10         = 10'(paddle_x);
    paddle_hit_c = vy_n[VDIR] && (nyu + BS10 >= PY10) && (prev_bot <= PY10) &&
                   (nxu + BS10 > px10) && (nxu < px10 + PW10);
    new_x        = X_W'(nxu);
    new_y        = Y_W'(nyu);
    if (paddle_hit_c) begin
      new_y      = REST_Y;
      vy_n[VDIR] = 1'b0;
    end
    miss_c       = !paddle_hit_c && (ny > Y_MAX);
`ifdef BALL_SPEEDUP_EN
    if ((cx_lat || cy_lat) && (hit_cnt == 3'd7)) begin
      vx_n[VMAG_HI:VMAG_LO] = mag_inc(vx[VMAG_HI:VMAG_LO]);
      vy_n[VMAG_HI:VMAG_LO] = mag_inc(vy[VMAG_HI:VMAG_LO]);
    end
`endif
  end

  // A scan is armed in the cycle that commits a transition into DRAW or ERASE.
  always_comb begin
    scan_start_c = 1'b0;
    case (state)
      ST_IDLE:      scan_start_c = launch;
      ST_WAIT_TICK: scan_start_c = tick_pend;
      ST_MOVE:      scan_start_c = !miss_c;
      default:      scan_start_c = 1'b0;
    endcase
  end

  // Control FSM with ball state, tick and collision latches.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state     <= ST_IDLE;
      ballX     <= RESET_X;
      ballY     <= REST_Y;
      vx        <= VX_LAUNCH;
      vy        <= VY_LAUNCH;
      tick_pend <= 1'b0;
      cx_lat    <= 1'b0;
      cy_lat    <= 1'b0;
      miss      <= 1'b0;
      active    <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      hit_cnt   <= 3'd0;
`endif
    end else begin
      miss <= 1'b0;
      if (state == ST_IDLE) begin
        cx_lat    <= 1'b0;
        cy_lat    <= 1'b0;
        tick_pend <= 1'b0;
      end else begin
        // MOVE consumes the latches but keeps a pulse arriving in that cycle.
        if (state == ST_MOVE) begin
          cx_lat <= cX;
          cy_lat <= cY;
        end else begin
          cx_lat <= cx_lat | cX;
          cy_lat <= cy_lat | cY;
        end
        // Entry to ERASE wins over a coincident tick, which is dropped.
        if ((state == ST_WAIT_TICK) && tick_pend) begin
          tick_pend <= 1'b0;
        end else if (frame_tick) begin
          tick_pend <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (launch) begin
            ballX  <= paddle_x + LAUNCH_OFS;
            ballY  <= REST_Y;
            vx     <= VX_LAUNCH;
            vy     <= VY_LAUNCH;
            active <= 1'b1;
            state  <= ST_DRAW;
`ifdef BALL_SPEEDUP_EN
            hit_cnt <= 3'd0;
`endif
          end
        end
        ST_DRAW: begin
          if (scan_done_c) state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (tick_pend) state <= ST_ERASE;
        end
        ST_ERASE: begin
          if (scan_done_c) state <= ST_MOVE;
        end
        ST_MOVE: begin
          if (miss_c) begin
            // Sprite is already erased; position and velocity are frozen.
            miss   <= 1'b1;
            active <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            ballX <= new_x;
            ballY <= new_y;
            vx    <= vx_n;
            vy    <= vy_n;
            state <= ST_DRAW;
`ifdef BALL_SPEEDUP_EN
            if (cx_lat || cy_lat) hit_cnt <= hit_cnt + 3'd1;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Registered pixel stream: white while drawing, black while erasing.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      outX     <= '0;
      outY     <= '0;
      outCOLOR <= COLOR_BLACK;
      plot     <= 1'b0;
    end else begin
      plot <= scan_valid_c && ((state == ST_DRAW) || (state == ST_ERASE));
      if (scan_valid_c) begin
        outX     <= pix_x_c;
        outY     <= pix_y_c;
        outCOLOR <= (state == ST_DRAW) ? BALL_COLOR : COLOR_BLACK;
      end
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: randomized launches, ticks, brick pulses
// and paddle placements against a behavioural model of the ball physics.
module tb_ball_motion;

  logic       Clock = 1'b0;
  logic       Resetn, frame_tick, launch, cX, cY;
  logic [7:0] paddle_x;
  logic [7:0] ballX, outX;
  logic [6:0] ballY, outY;
  logic [2:0] vx, vy, outCOLOR;
  logic       plot, miss, active;

  ball_motion dut (
    .Clock(Clock), .Resetn(Resetn), .frame_tick(frame_tick), .launch(launch),
    .paddle_x(paddle_x), .cX(cX), .cY(cY), .ballX(ballX), .ballY(ballY),
    .vx(vx), .vy(vy), .outX(outX), .outY(outY), .outCOLOR(outCOLOR),
    .plot(plot), .miss(miss), .active(active)
  );

  always #5 Clock = ~Clock;

  typedef struct { int x; int y; int c; } pix_t;
  pix_t exp_q[$];

  int checks = 0, errors = 0;
  int miss_seen = 0, exp_miss = 0;

  // Reference ball: position, direction bits, magnitude, pending brick flips.
  int m_x, m_y, m_dx, m_dy, m_mag, m_cnt;
  bit p_cx, p_cy;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  function automatic void push_sprite(input int x, input int y, input int c);
    pix_t p;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 2; k++) begin
        p.x = x + k; p.y = y + r; p.c = c;
        exp_q.push_back(p);
      end
  endfunction

  function automatic void model_reset();
    m_x = 79; m_y = 110; m_dx = 1; m_dy = 0; m_mag = 1; m_cnt = 0;
    p_cx = 0; p_cy = 0;
  endfunction

  function automatic void model_launch(input int px);
    m_x = (px + 7) % 256; m_y = 110; m_dx = 1; m_dy = 0; m_mag = 1; m_cnt = 0;
    p_cx = 0; p_cy = 0;
    push_sprite(m_x, m_y, 7);
  endfunction

  // Frame step from the physics rules; returns 1 when the ball is lost.
  function automatic bit model_move(input int px);
    int x, y, dx, dy, mag, cnt;
    bit hit;
    push_sprite(m_x, m_y, 0);
    dx = p_cx ? 1 - m_dx : m_dx;
    dy = p_cy ? 1 - m_dy : m_dy;
    hit = p_cx || p_cy;
    p_cx = 0; p_cy = 0;
    mag = m_mag; cnt = m_cnt;
`ifdef BALL_SPEEDUP_EN
    if (hit) begin
      cnt++;
      if (cnt % 8 == 0 && mag < 3) mag = mag + 1;
    end
`endif
    x = m_x + (dx ? m_mag : -m_mag);
    y = m_y + (dy ? m_mag : -m_mag);
    if (x < 0) begin x = 0; dx = 1; end
    else if (x > 158) begin x = 158; dx = 0; end
    if (y < 0) begin y = 0; dy = 1; end
    if (dy == 1 && y + 2 >= 112 && m_y + 2 <= 112 && x + 2 > px && x < px + 16) begin
      y = 110; dy = 0;
    end else if (y > 118) begin
      return 1'b1;
    end
    m_x = x; m_y = y; m_dx = dx; m_dy = dy; m_mag = mag; m_cnt = cnt;
    push_sprite(m_x, m_y, 7);
    return 1'b0;
  endfunction

  // Monitor: every presented pixel is matched against the scoreboard head.
  always @(negedge Clock) begin
    pix_t e;
    if (plot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected got (%0d,%0d) c%0d want none", outX, outY, outCOLOR);
      end else begin
        e = exp_q.pop_front();
        if (int'(outX) != e.x || int'(outY) != e.y || int'(outCOLOR) != e.c) begin
          errors++;
          $display("FAIL pixel got (%0d,%0d) c%0d want (%0d,%0d) c%0d",
                   outX, outY, outCOLOR, e.x, e.y, e.c);
        end
      end
    end
    if (miss) miss_seen++;
  end

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_regs(input int want_active);
    chk("ballX", int'(ballX), m_x);
    chk("ballY", int'(ballY), m_y);
    chk("vx", int'(vx), m_dx * 4 + m_mag);
    chk("vy", int'(vy), m_dy * 4 + m_mag);
    chk("active", int'(active), want_active);
  endtask

  task automatic do_launch(input int px);
    paddle_x = 8'(px);
    launch = 1'b1;
    step();
    model_launch(px);
    if ($urandom_range(0, 1) == 1) step();
    launch = 1'b0;
    wait_drain();
    step(); step();
    check_regs(1);
  endtask

  task automatic hard_reset();
    Resetn = 1'b0;
    step(); step();
    Resetn = 1'b1;
    exp_q.delete();
    model_reset();
    step();
  endtask

  // One frame: optional brick pulses, paddle placement, tick, optional MOVE pulse.
  task automatic do_move(output bit lost);
    int px, n;
    bit pcx, pcy, dbl, mvx, mvy;
    pcx = ($urandom_range(0, 15) == 0);
    pcy = ($urandom_range(0, 15) == 0);
    if (pcx || pcy) begin
      cX = pcx; cY = pcy;
      step();
      cX = 1'b0; cY = 1'b0;
      p_cx |= pcx; p_cy |= pcy;
    end
    if ($urandom_range(0, 3) == 0) begin
      px = m_x - int'($urandom_range(0, 14));
      if (px < 0) px = 0;
    end else begin
      px = int'($urandom_range(0, 144));
    end
    paddle_x = 8'(px);
    dbl = ($urandom_range(0, 7) == 0);
    mvx = ($urandom_range(0, 15) == 0);
    mvy = ($urandom_range(0, 15) == 0);
    frame_tick = 1'b1;
    step();
    lost = model_move(px);
    n = 1;
    if (dbl) begin
      step();
      n = 2;
    end
    frame_tick = 1'b0;
    for (int i = n; i < 6; i++) step();
    cX = mvx; cY = mvy;
    step();
    cX = 1'b0; cY = 1'b0;
    if (!lost) begin
      p_cx |= mvx; p_cy |= mvy;
    end
    wait_drain();
    step(); step(); step();
    if (lost) begin
      exp_miss++;
      chk("miss_count", miss_seen, exp_miss);
      check_regs(0);
      chk("plot_idle", int'(plot), 0);
    end else begin
      check_regs(1);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int total, lives;
    bit lost;
    Resetn = 1'b0; frame_tick = 1'b0; launch = 1'b0; cX = 1'b0; cY = 1'b0;
    paddle_x = 8'd0;
    model_reset();
    step(); step();
    chk("rst_plot", int'(plot), 0);
    chk("rst_outX", int'(outX), 0);
    chk("rst_outY", int'(outY), 0);
    chk("rst_outCOLOR", int'(outCOLOR), 0);
    chk("rst_miss", int'(miss), 0);
    check_regs(0);
    Resetn = 1'b1;
    step();

    // IDLE ignores ticks and collision pulses.
    cX = 1'b1; cY = 1'b1; frame_tick = 1'b1;
    step();
    cX = 1'b0; cY = 1'b0; frame_tick = 1'b0;
    step(); step();
    chk("idle_active", int'(active), 0);
    chk("idle_plot", int'(plot), 0);

    do_launch(40);

    // Reset in the middle of a draw scan.
    hard_reset();
    paddle_x = 8'd90;
    launch = 1'b1;
    step();
    model_launch(90);
    launch = 1'b0;
    Resetn = 1'b0;
    step();
    chk("rst_mid_plot", int'(plot), 0);
    exp_q.delete();
    model_reset();
    check_regs(0);
    step();
    chk("rst_mid_plot_hold", int'(plot), 0);
    Resetn = 1'b1;
    step();

    total = 0;
    lives = 0;
    while (total < 1200 && lives < 20) begin
      lives++;
      do_launch(int'($urandom_range(0, 144)));
      lost = 1'b0;
      for (int k = 0; k < 700 && !lost && total < 1200; k++) begin
        total++;
        do_move(lost);
      end
      if (!lost) hard_reset();
    end
    chk("miss_total", miss_seen, exp_miss);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
